// File: rtl/ca_stream_processor_nste.sv
// N_STE homogeneous automaton over a valid/ready symbol stream, 2-stage pipeline, backpressured report port.
// Optional CA_REPORT_COUNT_EN adds a saturating report-handshake counter output rpt_count.
module ca_stream_processor_nste #(
   parameter int unsigned N_STE = 8,
   parameter int unsigned SYM_W = 8,
   parameter logic [N_STE*(1<<SYM_W)-1:0] MATCH_TABLE = '0,
   parameter logic [N_STE*N_STE-1:0] ROUTE = '0,
   parameter logic [N_STE-1:0] START_VEC = '0,
   parameter logic [N_STE-1:0] END_VEC = '0,
   parameter int unsigned START_MODE = 0,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SYM_W-1:0] in_sym,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic             rpt_valid,
   input  logic             rpt_ready,
   output logic [N_STE-1:0] rpt_ste,
   output logic [CNT_W-1:0] rpt_offset,
   output logic [N_STE-1:0] active_vec
`ifdef CA_REPORT_COUNT_EN
   ,
   output logic [CNT_W-1:0] rpt_count
`endif
);

   localparam int unsigned NSYM = 1 << SYM_W;

   logic             adv;
   logic             accept;
   logic [NSYM-1:0]  row;
   logic [N_STE-1:0] cls;
   logic [N_STE-1:0] start_en;
   logic [N_STE-1:0] en;
   logic [N_STE-1:0] route_or;
   logic             hit;

   logic             v1_q, v1_d;
   logic [N_STE-1:0] match1_q, match1_d;
   logic [CNT_W-1:0] off1_q, off1_d;
   logic             last1_q, last1_d;
   logic [CNT_W-1:0] offset_q, offset_d;
   logic [N_STE-1:0] active_q, active_d;
   logic             rpt_valid_q, rpt_valid_d;
   logic [N_STE-1:0] rpt_ste_q, rpt_ste_d;
   logic [CNT_W-1:0] rpt_off_q, rpt_off_d;
`ifdef CA_REPORT_COUNT_EN
   logic [CNT_W-1:0] rpt_count_q, rpt_count_d;
`endif

   // Whole pipeline freezes only while a report is held back by the collector.
   always_comb begin
      adv    = !(rpt_valid_q && !rpt_ready);
      accept = in_valid && adv;
   end

   always_comb begin
      row = '0;
      cls = '0;
      for (int unsigned i = 0; i < N_STE; i++) begin
         row    = MATCH_TABLE[i*NSYM +: NSYM];
         cls[i] = row[in_sym];
      end
   end

   always_comb begin
      start_en = (START_MODE == 0 || off1_q == '0) ? START_VEC : '0;
      en       = match1_q & (active_q | start_en);
      hit      = |(en & END_VEC);
      route_or = '0;
      for (int unsigned i = 0; i < N_STE; i++) begin
         if (en[i]) begin
            route_or = route_or | ROUTE[i*N_STE +: N_STE];
         end
      end
   end

   always_comb begin
      v1_d        = v1_q;
      match1_d    = match1_q;
      off1_d      = off1_q;
      last1_d     = last1_q;
      offset_d    = offset_q;
      active_d    = active_q;
      rpt_valid_d = rpt_valid_q;
      rpt_ste_d   = rpt_ste_q;
      rpt_off_d   = rpt_off_q;

      if (accept) begin
         offset_d = in_last ? '0 : offset_q + CNT_W'(1);
      end

      if (adv) begin
         v1_d        = accept;
         rpt_valid_d = v1_q && hit;
         if (accept) begin
            match1_d = cls;
            off1_d   = offset_q;
            last1_d  = in_last;
         end
         if (v1_q) begin
            active_d = last1_q ? '0 : route_or;
            if (hit) begin
               rpt_ste_d = en & END_VEC;
               rpt_off_d = off1_q;
            end
         end
      end
   end

`ifdef CA_REPORT_COUNT_EN
   always_comb begin
      rpt_count_d = rpt_count_q;
      if (rpt_valid_q && rpt_ready && !(&rpt_count_q)) begin
         rpt_count_d = rpt_count_q + CNT_W'(1);
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q        <= 1'b0;
         match1_q    <= '0;
         off1_q      <= '0;
         last1_q     <= 1'b0;
         offset_q    <= '0;
         active_q    <= '0;
         rpt_valid_q <= 1'b0;
         rpt_ste_q   <= '0;
         rpt_off_q   <= '0;
`ifdef CA_REPORT_COUNT_EN
         rpt_count_q <= '0;
`endif
      end else begin
         v1_q        <= v1_d;
         match1_q    <= match1_d;
         off1_q      <= off1_d;
         last1_q     <= last1_d;
         offset_q    <= offset_d;
         active_q    <= active_d;
         rpt_valid_q <= rpt_valid_d;
         rpt_ste_q   <= rpt_ste_d;
         rpt_off_q   <= rpt_off_d;
`ifdef CA_REPORT_COUNT_EN
         rpt_count_q <= rpt_count_d;
`endif
      end
   end

   always_comb begin
      in_ready   = adv;
      rpt_valid  = rpt_valid_q;
      rpt_ste    = rpt_ste_q;
      rpt_offset = rpt_off_q;
      active_vec = active_q;
`ifdef CA_REPORT_COUNT_EN
      rpt_count  = rpt_count_q;
`endif
   end

endmodule

// File: tb/tb_ca_stream_processor_nste.sv
// Bench: three instances (all-input, start-of-data, 4-bit offset) of the 'a' then 'b' automaton,
// directed scenarios plus random traffic checked against a transaction-level model.
module tb_ca_stream_processor_nste;

   localparam logic [511:0] MT = (512'(1) << 'h61) | (512'(1) << (256 + 'h62));
   localparam logic [3:0]   RT = 4'b0010;
   localparam logic [7:0]   SYM_X = 8'h78;
   localparam logic [7:0]   SYM_A = 8'h61;
   localparam logic [7:0]   SYM_B = 8'h62;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  in_valid, in_last, in_ready, rpt_valid, rpt_ready;
   logic [7:0]  in_sym [3];
   logic [1:0]  rpt_ste [3];
   logic [1:0]  active_vec [3];
   logic [15:0] rpt_offset [3];
`ifdef CA_REPORT_COUNT_EN
   logic [15:0] rpt_count [3];
`endif

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned CW = (g == 2) ? 4 : 16;
      logic [CW-1:0] off_w;
`ifdef CA_REPORT_COUNT_EN
      logic [CW-1:0] cnt_w;
      assign rpt_count[g] = 16'(cnt_w);
`endif
      ca_stream_processor_nste #(
         .N_STE(2), .SYM_W(8), .MATCH_TABLE(MT), .ROUTE(RT),
         .START_VEC(2'b01), .END_VEC(2'b10),
         .START_MODE((g == 1) ? 1 : 0), .CNT_W(CW)
      ) u_dut (
         .clk(clk), .rst(rst),
         .in_sym(in_sym[g]), .in_valid(in_valid[g]), .in_last(in_last[g]), .in_ready(in_ready[g]),
         .rpt_valid(rpt_valid[g]), .rpt_ready(rpt_ready[g]), .rpt_ste(rpt_ste[g]),
         .rpt_offset(off_w), .active_vec(active_vec[g])
`ifdef CA_REPORT_COUNT_EN
         , .rpt_count(cnt_w)
`endif
      );
      assign rpt_offset[g] = 16'(off_w);
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_valid[k] = 1'b0; in_last[k] = 1'b0; in_sym[k] = '0; rpt_ready[k] = 1'b1;
      end
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic send(input int k, input logic [7:0] s, input logic l);
      in_sym[k] = s; in_valid[k] = 1'b1; in_last[k] = l;
      for (int n = 0; n < 50; n++) begin
         #1;
         if (in_ready[k]) begin
            @(posedge clk);
            #1;
            in_valid[k] = 1'b0; in_last[k] = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      check_eq("send_timeout", 32'(in_ready[k]), 1);
      in_valid[k] = 1'b0; in_last[k] = 1'b0;
   endtask

   task automatic wait_rpt(input int k, input int max, output bit found);
      found = 1'b0;
      for (int n = 0; n < max; n++) begin
         if (rpt_valid[k]) begin
            found = 1'b1;
            return;
         end
         tick();
      end
      found = rpt_valid[k];
   endtask

   // Reference model: an 'a' seen where a start is allowed arms the following symbol; 'b' on an armed slot reports.
   typedef struct { int k; logic [1:0] ste; int unsigned off; } rpt_t;
   rpt_t        exp_q [$];
   bit          m_armed [3];
   int unsigned m_off [3];

   function automatic int unsigned modulus(input int k);
      return (k == 2) ? 16 : 65536;
   endfunction

   function automatic void model_step(input int k, input logic [7:0] s, input logic l);
      bit start_ok;
      bit nxt;
      rpt_t r;
      start_ok = (k != 1) || (m_off[k] == 0);
      nxt = (s == SYM_A) && start_ok;
      if (s == SYM_B && m_armed[k]) begin
         r.k = k; r.ste = 2'b10; r.off = m_off[k];
         exp_q.push_back(r);
      end
      m_armed[k] = l ? 1'b0 : nxt;
      m_off[k]   = l ? 0 : (m_off[k] + 1) % modulus(k);
   endfunction

   task automatic pop_compare(input int k);
      bit found = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (exp_q[i].k == k) begin
            found = 1'b1;
            check_eq("rand_rpt_ste", 32'(rpt_ste[k]), 32'(exp_q[i].ste));
            check_eq("rand_rpt_off", 32'(rpt_offset[k]), exp_q[i].off);
            exp_q.delete(i);
            break;
         end
      end
      check_eq("rand_rpt_expected", 32'(found), 1);
   endtask

   bit          stalled [3];
   logic [1:0]  sv_ste [3];
   logic [15:0] sv_off [3];

   task automatic rand_cycle(input bit drain);
      int r;
      for (int k = 0; k < 3; k++) begin
         if (stalled[k]) begin
            check_eq("hold_valid", 32'(rpt_valid[k]), 1);
            check_eq("hold_ste", 32'(rpt_ste[k]), 32'(sv_ste[k]));
            check_eq("hold_off", 32'(rpt_offset[k]), 32'(sv_off[k]));
         end
         if (drain) begin
            in_valid[k] = 1'b0; in_last[k] = 1'b0; rpt_ready[k] = 1'b1;
         end else begin
            r = $urandom_range(0, 3);
            in_sym[k]    = (r == 0) ? SYM_X : (r == 1) ? SYM_A : (r == 2) ? SYM_B : 8'($urandom);
            in_valid[k]  = ($urandom_range(0, 3) != 0);
            in_last[k]   = ($urandom_range(0, 15) == 0);
            rpt_ready[k] = ($urandom_range(0, 4) < 3);
         end
      end
      #1;
      for (int k = 0; k < 3; k++) begin
         check_eq("in_ready_rule", 32'(in_ready[k]), 32'(!(rpt_valid[k] && !rpt_ready[k])));
         if (in_valid[k] && in_ready[k]) model_step(k, in_sym[k], in_last[k]);
         if (rpt_valid[k] && rpt_ready[k]) pop_compare(k);
         stalled[k] = rpt_valid[k] && !rpt_ready[k];
         sv_ste[k]  = rpt_ste[k];
         sv_off[k]  = rpt_offset[k];
      end
      tick();
   endtask

   initial begin
      bit found;
      do_reset();

      // 1: all-input mode, 'x','a','b'
      check_eq("rst_rpt_valid", 32'(rpt_valid[0]), 0);
      check_eq("rst_active", 32'(active_vec[0]), 0);
      check_eq("rst_rpt_ste", 32'(rpt_ste[0]), 0);
      check_eq("rst_rpt_off", 32'(rpt_offset[0]), 0);
      check_eq("rst_in_ready", 32'(in_ready[0]), 1);
      send(0, SYM_X, 0); send(0, SYM_A, 0); send(0, SYM_B, 0);
      check_eq("t1_active_after_a", 32'(active_vec[0]), 2);
      check_eq("t1_no_early_rpt", 32'(rpt_valid[0]), 0);
      wait_rpt(0, 2, found);
      check_eq("t1_rpt_seen", 32'(found), 1);
      check_eq("t1_rpt_ste", 32'(rpt_ste[0]), 2);
      check_eq("t1_rpt_off", 32'(rpt_offset[0]), 2);
      tick();
      check_eq("t1_no_dup", 32'(rpt_valid[0]), 0);
`ifdef CA_REPORT_COUNT_EN
      check_eq("t1_count", 32'(rpt_count[0]), 1);
`endif

      // 2: start-of-data mode
      do_reset();
      send(1, SYM_X, 0); send(1, SYM_A, 0); send(1, SYM_B, 1);
      for (int n = 0; n < 4; n++) begin
         check_eq("t2_no_rpt", 32'(rpt_valid[1]), 0);
         tick();
      end
      send(1, SYM_A, 0); send(1, SYM_B, 0);
      wait_rpt(1, 2, found);
      check_eq("t2_rpt_seen", 32'(found), 1);
      check_eq("t2_rpt_off", 32'(rpt_offset[1]), 1);

      // 3: backpressure
      do_reset();
      rpt_ready[0] = 1'b0;
      send(0, SYM_A, 0); send(0, SYM_B, 0); send(0, SYM_A, 0);
      in_sym[0] = SYM_B; in_valid[0] = 1'b1;
      wait_rpt(0, 3, found);
      check_eq("t3_rpt1_seen", 32'(found), 1);
      for (int n = 0; n < 3; n++) begin
         check_eq("t3_stall_ready", 32'(in_ready[0]), 0);
         check_eq("t3_stall_valid", 32'(rpt_valid[0]), 1);
         check_eq("t3_stall_off", 32'(rpt_offset[0]), 1);
         tick();
      end
      rpt_ready[0] = 1'b1;
      #1;
      check_eq("t3_release_ready", 32'(in_ready[0]), 1);
      tick();
      in_valid[0] = 1'b0;
      check_eq("t3_retired", 32'(rpt_valid[0]), 0);
      wait_rpt(0, 3, found);
      check_eq("t3_rpt2_seen", 32'(found), 1);
      check_eq("t3_rpt2_off", 32'(rpt_offset[0]), 3);
      tick();
`ifdef CA_REPORT_COUNT_EN
      check_eq("t3_count", 32'(rpt_count[0]), 2);
`endif

      // 4: in_last on 'a' clears the active set and restarts the offset
      do_reset();
      send(0, SYM_A, 1);
      tick();
      check_eq("t4_active_cleared", 32'(active_vec[0]), 0);
      send(0, SYM_B, 0);
      for (int n = 0; n < 3; n++) begin
         check_eq("t4_no_rpt", 32'(rpt_valid[0]), 0);
         tick();
      end
      send(0, SYM_A, 0); send(0, SYM_B, 0);
      wait_rpt(0, 3, found);
      check_eq("t4_rpt_seen", 32'(found), 1);
      check_eq("t4_rpt_off", 32'(rpt_offset[0]), 2);

      // 5: 4-bit offset wrap
      do_reset();
      for (int n = 0; n < 17; n++) send(2, SYM_X, 0);
      send(2, SYM_A, 0); send(2, SYM_B, 0);
      wait_rpt(2, 3, found);
      check_eq("t5_rpt_seen", 32'(found), 1);
      check_eq("t5_rpt_off", 32'(rpt_offset[2]), 2);

      // 6: async reset with a pending report
      do_reset();
      rpt_ready[0] = 1'b0;
      send(0, SYM_A, 0); send(0, SYM_B, 0); send(0, SYM_A, 0);
      wait_rpt(0, 3, found);
      check_eq("t6_pending", 32'(found), 1);
      #2;
      rst = 1'b1;
      #1;
      check_eq("t6_rst_valid", 32'(rpt_valid[0]), 0);
      check_eq("t6_rst_active", 32'(active_vec[0]), 0);
      check_eq("t6_rst_off", 32'(rpt_offset[0]), 0);
`ifdef CA_REPORT_COUNT_EN
      check_eq("t6_rst_count", 32'(rpt_count[0]), 0);
`endif
      tick();
      rst = 1'b0;
      rpt_ready[0] = 1'b1;
      tick();
      send(0, SYM_A, 0); send(0, SYM_B, 0);
      wait_rpt(0, 3, found);
      check_eq("t6_rpt_seen", 32'(found), 1);
      check_eq("t6_rpt_off", 32'(rpt_offset[0]), 1);

      // Random traffic on all three instances
      do_reset();
      for (int k = 0; k < 3; k++) begin
         m_armed[k] = 1'b0; m_off[k] = 0; stalled[k] = 1'b0;
      end
      exp_q.delete();
      for (int n = 0; n < 3000; n++) rand_cycle(1'b0);
      for (int n = 0; n < 10; n++) rand_cycle(1'b1);
      check_eq("rand_all_reported", 32'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
